muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer beside the bexkat1 execute stage. It accepts one multiply, divide or modulus request at a time and runs a 32-iteration shift-add or restoring-divide loop. While the operation is in flight it holds the pipeline stall. It presents a 32-bit result for one cycle, and the execute stage captures that result as its ALU output.

---
 rtl/muldiv_seq.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide sequencer beside the bexkat1 execute stage.
// Divider datapath is present only when BEXKAT1_MULDIV_DIV_EN is defined; otherwise divide ops return 0.
module muldiv_seq (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        abort_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic        divz_o
);
   typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

   localparam logic [2:0] OP_MUL   = 3'd0;
   localparam logic [2:0] OP_MULH  = 3'd1;
   localparam logic [2:0] OP_MULHU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MOD   = 3'd5;
   localparam logic [2:0] OP_MODU  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   state_t      state;
   logic [2:0]  op;
   logic [31:0] a_raw;
   logic [31:0] b_raw;
   logic [31:0] src;   // multiplicand (mul) or divisor (div) magnitude
   logic [31:0] shf;   // multiplier (mul) or dividend (div), consumed one bit per iteration
   logic [63:0] acc;
   logic [4:0]  cnt;
   logic        neg;
   logic        divz_pend;
   logic        busy;
   logic        done;
   logic        divz;
   logic [31:0] result;

   logic        is_div;
   logic        is_signed;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] mul_sum;
   logic [63:0] prod;
   logic [31:0] fix_result;

   assign is_div    = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MOD) || (op == OP_MODU);
   assign is_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
   assign mag_a     = (is_signed && a_raw[31]) ? (32'd0 - a_raw) : a_raw;
   assign mag_b     = (is_signed && b_raw[31]) ? (32'd0 - b_raw) : b_raw;
   assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, src};
   assign prod      = neg ? (64'd0 - acc) : acc;

`ifdef BEXKAT1_MULDIV_DIV_EN
   logic [32:0] rem_sh;
   logic [32:0] rem_sub;
   logic        rem_ge;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Remainder lives in acc[63:32], quotient bits shift into acc[31:0].
   assign rem_sh  = {acc[63:32], shf[31]};
   assign rem_sub = rem_sh - {1'b0, src};
   assign rem_ge  = (rem_sh >= {1'b0, src});
   assign quo_fix = neg ? (32'd0 - acc[31:0])  : acc[31:0];
   assign rem_fix = neg ? (32'd0 - acc[63:32]) : acc[63:32];
`endif

   always_comb begin
      fix_result = '0;
      case (op)
         OP_MUL:   fix_result = prod[31:0];
         OP_MULH:  fix_result = prod[63:32];
         OP_MULHU: fix_result = acc[63:32];
`ifdef BEXKAT1_MULDIV_DIV_EN
         OP_DIV, OP_DIVU: fix_result = divz_pend ? 32'hFFFF_FFFF : quo_fix;
         OP_MOD, OP_MODU: fix_result = divz_pend ? a_raw : rem_fix;
`endif
         default:  fix_result = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         op        <= '0;
         a_raw     <= '0;
         b_raw     <= '0;
         src       <= '0;
         shf       <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         divz_pend <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         divz      <= 1'b0;
         result    <= '0;
      end else if (abort_i) begin
         // Flush: results from earlier operations stay visible.
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start_i && (op_i != OP_RSVD)) begin
                  op    <= op_i;
                  a_raw <= a_i;
                  b_raw <= b_i;
                  busy  <= 1'b1;
                  state <= PREP;
               end
            end
            PREP: begin
               acc <= '0;
               cnt <= '0;
               if (op == OP_MOD)
                  neg <= a_raw[31];
               else if ((op == OP_MULH) || (op == OP_DIV))
                  neg <= a_raw[31] ^ b_raw[31];
               else
                  neg <= 1'b0;
               if (is_div) begin
                  src <= mag_b;
                  shf <= mag_a;
               end else begin
                  src <= mag_a;
                  shf <= mag_b;
               end
`ifdef BEXKAT1_MULDIV_DIV_EN
               divz_pend <= is_div && (b_raw == 32'd0);
               state     <= (is_div && (b_raw == 32'd0)) ? FIX : RUN;
`else
               divz_pend <= 1'b0;
               state     <= is_div ? FIX : RUN;
`endif
            end
            RUN: begin
`ifdef BEXKAT1_MULDIV_DIV_EN
               if (is_div) begin
                  acc <= {(rem_ge ? rem_sub[31:0] : rem_sh[31:0]), acc[30:0], rem_ge};
                  shf <= {shf[30:0], 1'b0};
               end else
`endif
               begin
                  if (shf[0])
                     acc <= {mul_sum, acc[31:1]};
                  else
                     acc <= {1'b0, acc[63:1]};
                  shf <= {1'b0, shf[31:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31)
                  state <= FIX;
            end
            FIX: begin
               result <= fix_result;
               divz   <= divz_pend;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stall_o  = ((state == IDLE) && start_i && (op_i != OP_RSVD)) ||
                     (state == PREP) || (state == RUN) || (state == FIX);
   assign busy_o   = busy;
   assign done_o   = done;
   assign result_o = result;
   assign divz_o   = divz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard testbench for muldiv_seq; expectations follow BEXKAT1_MULDIV_DIV_EN when defined.
module tb_muldiv_seq;
`ifdef BEXKAT1_MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        abort_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic        divz_o;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] last_res = 32'd0;

   typedef struct {
      logic [31:0] res;
      logic        dz;
      int          lat;
      int          t0;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t scb[$];
   exp_t mon_e;

   muldiv_seq dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .abort_i  (abort_i),
      .stall_o  (stall_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .divz_o   (divz_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
      lat_of = 35;
      if (op >= 3'd3 && op <= 3'd6 && (b == 32'd0 || !DIV_EN))
         lat_of = 3;
   endfunction

   // Returns {divz, result}
   function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        up;
      logic [63:0]        sp;
      logic signed [31:0] sa;
      logic signed [31:0] sbv;
      logic signed [31:0] q;
      logic signed [31:0] r;
      up  = {32'd0, a} * {32'd0, b};
      sp  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      sa  = a;
      sbv = b;
      q   = 32'h8000_0000;
      r   = 32'd0;
      if (b != 32'd0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
         q = sa / sbv;
         r = sa % sbv;
      end
      case (op)
         3'd0: model = {1'b0, up[31:0]};
         3'd1: model = {1'b0, sp[63:32]};
         3'd2: model = {1'b0, up[63:32]};
         3'd3: model = (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, q};
         3'd4: model = (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
         3'd5: model = (b == 32'd0) ? {1'b1, a} : {1'b0, r};
         3'd6: model = (b == 32'd0) ? {1'b1, a} : {1'b0, a % b};
         default: model = 33'd0;
      endcase
      if (!DIV_EN && op >= 3'd3 && op <= 3'd6)
         model = 33'd0;
   endfunction

   // Drive one request, check stall/busy every cycle until done_o.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic dz);
      int lat;
      bit seen;
      lat  = lat_of(op, b);
      seen = 1'b0;
      @(posedge clk_i); #1;
      start_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      scb.push_back('{res: res, dz: dz, lat: lat, t0: cyc, op: op, a: a, b: b});
      for (int k = 0; k <= lat + 4; k++) begin
         @(negedge clk_i);
         chk("stall", 32'(stall_o), 32'(k < lat));
         chk("busy", 32'(busy_o), 32'(k >= 1 && k <= lat));
         if (done_o) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk_i); #1;
         start_i = 1'b0;
         op_i    = 3'($urandom_range(0, 7));
         a_i     = $urandom;
         b_i     = $urandom;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] m;
      m = model(op, a, b);
      issue(op, a, b, m[31:0], m[32]);
   endtask

   always @(negedge clk_i) begin
      if (done_o) begin
         if (scb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = scb.pop_front();
            $display("txn op=%0d a=%h b=%h result=%h divz=%b cycles=%0d",
                     mon_e.op, mon_e.a, mon_e.b, result_o, divz_o, cyc - mon_e.t0);
            chk("result", result_o, mon_e.res);
            chk("divz", 32'(divz_o), 32'(mon_e.dz));
            chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            last_res = mon_e.res;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      op_i    = 3'd0;
      a_i     = 32'd0;
      b_i     = 32'd0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_divz", 32'(divz_o), 32'd0);
      rst_i = 1'b0;

      issue(3'd0, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 1'b0);
      issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
      issue(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 1'b0);
      issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0);
`ifdef BEXKAT1_MULDIV_DIV_EN
      issue(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      issue(3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      issue(3'd4, 32'd100, 32'd7, 32'd14, 1'b0);
      issue(3'd6, 32'd100, 32'd7, 32'd2, 1'b0);
      issue(3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
      issue(3'd6, 32'h1234, 32'd0, 32'h1234, 1'b1);
`else
      issue(3'd3, 32'd10, 32'd2, 32'd0, 1'b0);
      issue(3'd5, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
      issue(3'd4, 32'h1234, 32'd0, 32'd0, 1'b0);
      issue(3'd0, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 1'b0);
`endif

      // Reset in the middle of an operation
      @(posedge clk_i); #1;
      start_i = 1'b1;
      op_i    = DIV_EN ? 3'd3 : 3'd0;
      a_i     = 32'd1000;
      b_i     = 32'd7;
      repeat (20) begin
         @(posedge clk_i); #1;
         start_i = 1'b0;
      end
      rst_i = 1'b1;
      #1;
      chk("midrst_stall", 32'(stall_o), 32'd0);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_done", 32'(done_o), 32'd0);
      chk("midrst_result", result_o, 32'd0);
      chk("midrst_divz", 32'(divz_o), 32'd0);
      last_res = 32'd0;
      @(negedge clk_i);
      rst_i = 1'b0;

`ifdef BEXKAT1_MULDIV_DIV_EN
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
`endif
      issue_model(3'd2, 32'hDEAD_BEEF, 32'h1234_5678);

      // Abort at cycle 10 of a multiply
      @(posedge clk_i); #1;
      start_i = 1'b1;
      op_i    = 3'd0;
      a_i     = 32'h0000_1111;
      b_i     = 32'h0000_2222;
      repeat (10) begin
         @(posedge clk_i); #1;
         start_i = 1'b0;
      end
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      @(negedge clk_i);
      chk("abort_stall", 32'(stall_o), 32'd0);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_done", 32'(done_o), 32'd0);
      chk("abort_result", result_o, last_res);
      issue_model(3'd0, 32'h0000_1111, 32'h0000_2222);

      // Reserved op is ignored
      @(posedge clk_i); #1;
      start_i = 1'b1;
      op_i    = 3'd7;
      #1;
      chk("rsvd_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("rsvd_busy", 32'(busy_o), 32'd0);

      for (int i = 0; i < 10; i++) begin
         logic [2:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 3'($urandom_range(0, 6));
         ra  = $urandom;
         rb  = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
         issue_model(rop, ra, rb);
      end

      repeat (3) @(negedge clk_i);
      chk("scoreboard_empty", 32'(scb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
